// File: rtl/key_vault_pkg.sv
// Shared encodings, FSM state type and slot-index width helper for the key vault.
package key_vault_pkg;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_LOCK    = 2'd2;
  localparam logic [1:0] OP_ZEROIZE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    ZERO = 1'b1
  } state_e;

  // Slot index width; a single-slot vault still carries a one-bit index.
  function automatic int unsigned slot_aw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_vault_slot.sv
// One key slot: key register with valid and sticky lock bits; clear wins over write/lock.
module key_vault_slot #(
  parameter int unsigned KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             lock_en,
  input  logic             clr_en,
  input  logic [KEY_W-1:0] wdata,
  output logic [KEY_W-1:0] key,
  output logic             valid,
  output logic             locked
);

  logic [KEY_W-1:0] key_q, key_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  // Next-state for the slot; zeroize clears key, valid and lock together.
  always_comb begin
    key_d    = key_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    if (clr_en) begin
      key_d    = '0;
      valid_d  = 1'b0;
      locked_d = 1'b0;
    end else begin
      if (wr_en) begin
        key_d   = wdata;
        valid_d = 1'b1;
      end
      if (lock_en) begin
        locked_d = 1'b1;
      end
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign key    = key_q;
  assign valid  = valid_q;
  assign locked = locked_q;

endmodule

// File: rtl/key_vault.sv
// Multi-slot key store with privilege-gated reads, sticky locks and sequential zeroize.
module key_vault
  import key_vault_pkg::*;
#(
  parameter  int unsigned KEY_W     = 32,
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned SLOT_AW   = slot_aw(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [SLOT_AW-1:0]   req_slot,
  input  logic                 req_priv,
  input  logic [KEY_W-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [KEY_W-1:0]     rsp_data,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [NUM_SLOTS-1:0] slot_locked,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [SLOT_AW-1:0] cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [KEY_W-1:0]   rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;

  logic [KEY_W-1:0]     slot_key [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] wr_en_c, lock_en_c, clr_en_c;

  logic               sel_hit;
  logic               sel_valid;
  logic               sel_locked;
  logic [KEY_W-1:0]   sel_key;
  logic               do_write;
  logic               do_lock;

  // Key slot array.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    key_vault_slot #(.KEY_W(KEY_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_c[gi]),
      .lock_en (lock_en_c[gi]),
      .clr_en  (clr_en_c[gi]),
      .wdata   (req_wdata),
      .key     (slot_key[gi]),
      .valid   (slot_valid[gi]),
      .locked  (slot_locked[gi])
    );
  end

  // Addressed-slot lookup; an index past the last slot leaves sel_hit low.
  always_comb begin
    sel_hit    = 1'b0;
    sel_valid  = 1'b0;
    sel_locked = 1'b0;
    sel_key    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (req_slot == SLOT_AW'(i)) begin
        sel_hit    = 1'b1;
        sel_valid  = slot_valid[i];
        sel_locked = slot_locked[i];
        sel_key    = slot_key[i];
      end
    end
  end

  // FSM next-state, permission checks and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    busy_d      = 1'b0;
    do_write    = 1'b0;
    do_lock     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_valid_d = 1'b1;
          case (req_op)
            OP_READ: begin
              if (!sel_hit || !sel_valid || (sel_locked && !req_priv)) begin
                rsp_err_d = 1'b1;
              end else begin
                rsp_data_d = sel_key;
              end
            end
            OP_WRITE: begin
              if (!sel_hit || sel_locked) begin
                rsp_err_d = 1'b1;
              end else begin
                do_write = 1'b1;
              end
            end
            OP_LOCK: begin
              if (!sel_hit || !sel_valid) begin
                rsp_err_d = 1'b1;
              end else begin
                do_lock = 1'b1;
              end
            end
            default: begin
              if (!req_priv) begin
                rsp_err_d = 1'b1;
              end else begin
                rsp_valid_d = 1'b0;
                state_d     = ZERO;
                cnt_d       = '0;
                busy_d      = 1'b1;
              end
            end
          endcase
        end
      end
      ZERO: begin
        busy_d = 1'b1;
        if (cnt_q == SLOT_AW'(NUM_SLOTS - 1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = SLOT_AW'(cnt_q + 1'b1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-slot strobes: write/lock from the decoded request, clear from the zeroize counter.
  always_comb begin
    wr_en_c   = '0;
    lock_en_c = '0;
    clr_en_c  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_en_c[i]   = do_write && (req_slot == SLOT_AW'(i));
      lock_en_c[i] = do_lock && (req_slot == SLOT_AW'(i));
      clr_en_c[i]  = (state_q == ZERO) && (cnt_q == SLOT_AW'(i));
    end
  end

  // FSM, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_key_vault.sv
// Directed bench for key_vault: default 4-slot instance plus a 3-slot instance for range checks.
module tb_key_vault;
  import key_vault_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_priv;
  logic [1:0]  req_op, req_slot;
  logic [31:0] req_wdata, rsp_data;
  logic        rsp_valid, rsp_err, busy;
  logic [3:0]  slot_valid, slot_locked;

  logic        r3_valid, r3_ready, r3_priv;
  logic [1:0]  r3_op, r3_slot;
  logic [31:0] r3_wdata, r3_data;
  logic        r3_rsp_valid, r3_err, r3_busy;
  logic [2:0]  r3_slot_valid, r3_slot_locked;

  int n_vec = 0;
  int n_err = 0;

  key_vault #(.KEY_W(32), .NUM_SLOTS(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_slot(req_slot),
    .req_priv(req_priv), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .slot_valid(slot_valid), .slot_locked(slot_locked), .busy(busy)
  );

  key_vault #(.KEY_W(32), .NUM_SLOTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_op(r3_op), .req_slot(r3_slot),
    .req_priv(r3_priv), .req_wdata(r3_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_err(r3_err), .rsp_data(r3_data),
    .slot_valid(r3_slot_valid), .slot_locked(r3_slot_locked), .busy(r3_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request at the negedge; return 1ns into the response cycle.
  task automatic send(input logic [1:0] op, input logic [1:0] slot, input logic priv,
                      input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_slot  = slot;
    req_priv  = priv;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] op, input logic [1:0] slot, input logic priv,
                       input logic [31:0] wd);
    @(negedge clk);
    r3_valid = 1'b1;
    r3_op    = op;
    r3_slot  = slot;
    r3_priv  = priv;
    r3_wdata = wd;
    @(posedge clk);
    #1;
    r3_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] mask;
    req_valid = 1'b0; req_op = 2'd0; req_slot = 2'd0; req_priv = 1'b0; req_wdata = '0;
    r3_valid = 1'b0; r3_op = 2'd0; r3_slot = 2'd0; r3_priv = 1'b0; r3_wdata = '0;

    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_slot_valid", 64'(slot_valid), 64'd0);
    chk("rst_slot_locked", 64'(slot_locked), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then unprivileged read of an unlocked slot.
    send(OP_WRITE, 2'd1, 1'b0, 32'hDEADBEEF);
    chk("wr1_valid", 64'(rsp_valid), 64'd1);
    chk("wr1_err", 64'(rsp_err), 64'd0);
    chk("wr1_data", 64'(rsp_data), 64'd0);
    chk("wr1_ready", 64'(req_ready), 64'd1);
    send(OP_READ, 2'd1, 1'b0, 32'h0);
    chk("rd1_valid", 64'(rsp_valid), 64'd1);
    chk("rd1_err", 64'(rsp_err), 64'd0);
    chk("rd1_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("rd1_slot_valid", 64'(slot_valid), 64'b0010);
    @(posedge clk); #1;
    chk("rd1_pulse_end", 64'(rsp_valid), 64'd0);
    chk("rd1_data_clear", 64'(rsp_data), 64'd0);

    // Lock, then locked-slot write and reads.
    send(OP_LOCK, 2'd1, 1'b0, 32'h0);
    chk("lk1_err", 64'(rsp_err), 64'd0);
    chk("lk1_locked", 64'(slot_locked), 64'b0010);
    send(OP_WRITE, 2'd1, 1'b1, 32'h12345678);
    chk("wr1_locked_err", 64'(rsp_err), 64'd1);
    send(OP_READ, 2'd1, 1'b0, 32'h0);
    chk("rd1_unpriv_err", 64'(rsp_err), 64'd1);
    chk("rd1_unpriv_data", 64'(rsp_data), 64'd0);
    send(OP_READ, 2'd1, 1'b1, 32'h0);
    chk("rd1_priv_err", 64'(rsp_err), 64'd0);
    chk("rd1_priv_data", 64'(rsp_data), 64'hDEADBEEF);
    send(OP_LOCK, 2'd1, 1'b0, 32'h0);
    chk("relock_err", 64'(rsp_err), 64'd0);

    // Unwritten slot.
    send(OP_READ, 2'd2, 1'b1, 32'h0);
    chk("rd2_err", 64'(rsp_err), 64'd1);
    chk("rd2_valid", 64'(rsp_valid), 64'd1);
    send(OP_LOCK, 2'd2, 1'b1, 32'h0);
    chk("lk2_err", 64'(rsp_err), 64'd1);
    chk("lk2_locked", 64'(slot_locked), 64'b0010);

    // Out-of-range slot on the 3-slot instance.
    send3(OP_WRITE, 2'd3, 1'b1, 32'h11111111);
    chk("s3_wr3_err", 64'(r3_err), 64'd1);
    chk("s3_slot_valid", 64'(r3_slot_valid), 64'b000);
    send3(OP_READ, 2'd3, 1'b1, 32'h0);
    chk("s3_rd3_valid", 64'(r3_rsp_valid), 64'd1);
    chk("s3_rd3_err", 64'(r3_err), 64'd1);
    send3(OP_WRITE, 2'd2, 1'b0, 32'h0BADF00D);
    send3(OP_READ, 2'd2, 1'b0, 32'h0);
    chk("s3_rd2_data", 64'(r3_data), 64'h0BADF00D);

    // Fill all slots, lock 0 and 3.
    send(OP_WRITE, 2'd0, 1'b0, 32'h00000A00);
    send(OP_WRITE, 2'd2, 1'b0, 32'h00000A02);
    send(OP_WRITE, 2'd3, 1'b0, 32'h00000A03);
    send(OP_LOCK, 2'd0, 1'b0, 32'h0);
    send(OP_LOCK, 2'd3, 1'b0, 32'h0);
    chk("fill_valid", 64'(slot_valid), 64'b1111);
    chk("fill_locked", 64'(slot_locked), 64'b1011);

    // Unprivileged zeroize is refused.
    send(OP_ZEROIZE, 2'd0, 1'b0, 32'h0);
    chk("zu_err", 64'(rsp_err), 64'd1);
    chk("zu_busy", 64'(busy), 64'd0);
    chk("zu_valid_slots", 64'(slot_valid), 64'b1111);
    chk("zu_locked_slots", 64'(slot_locked), 64'b1011);

    // Privileged zeroize with a read held waiting.
    send(OP_ZEROIZE, 2'd0, 1'b1, 32'h0);
    chk("z_n1_busy", 64'(busy), 64'd1);
    chk("z_n1_ready", 64'(req_ready), 64'd0);
    chk("z_n1_rsp", 64'(rsp_valid), 64'd0);
    chk("z_n1_valid", 64'(slot_valid), 64'b1111);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_READ; req_slot = 2'd0; req_priv = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      mask = 4'hF;
      mask = mask << (k - 1);
      chk("z_busy", 64'(busy), 64'd1);
      chk("z_rsp", 64'(rsp_valid), 64'd0);
      chk("z_slot_valid", 64'(slot_valid), 64'(mask));
    end
    @(posedge clk); #1;
    chk("z_done_rsp", 64'(rsp_valid), 64'd1);
    chk("z_done_err", 64'(rsp_err), 64'd0);
    chk("z_done_busy", 64'(busy), 64'd0);
    chk("z_done_ready", 64'(req_ready), 64'd1);
    chk("z_done_valid", 64'(slot_valid), 64'd0);
    chk("z_done_locked", 64'(slot_locked), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("z_held_rd_valid", 64'(rsp_valid), 64'd1);
    chk("z_held_rd_err", 64'(rsp_err), 64'd1);
    chk("z_held_rd_data", 64'(rsp_data), 64'd0);

    // Reset in the middle of a zeroize.
    send(OP_WRITE, 2'd0, 1'b0, 32'h00000B00);
    send(OP_WRITE, 2'd2, 1'b0, 32'h00000B02);
    send(OP_LOCK, 2'd2, 1'b0, 32'h0);
    send(OP_ZEROIZE, 2'd0, 1'b1, 32'h0);
    @(posedge clk); #1;
    chk("zr_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("zr_busy", 64'(busy), 64'd0);
    chk("zr_ready", 64'(req_ready), 64'd1);
    chk("zr_rsp", 64'(rsp_valid), 64'd0);
    chk("zr_slot_valid", 64'(slot_valid), 64'd0);
    chk("zr_slot_locked", 64'(slot_locked), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("zr_no_pulse", 64'(rsp_valid), 64'd0);
    end
    send(OP_WRITE, 2'd0, 1'b0, 32'hA5A5A5A5);
    send(OP_READ, 2'd0, 1'b0, 32'h0);
    chk("post_rd_err", 64'(rsp_err), 64'd0);
    chk("post_rd_data", 64'(rsp_data), 64'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
